axis_throttle_arbiter: RTL and testbench



---
 rtl/axis_throttle_pkg.sv | 13 +
 rtl/axis_throttle_slot.sv | 55 +++++
 rtl/axis_throttle_arbiter.sv | 102 ++++++++++
 tb/tb_axis_throttle_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_throttle_pkg.sv
// Shared widths and slot-period helper for the throttled AXI-Stream arbiter.
// Pure declarations: no latency and no flow-control behaviour of its own.
package axis_throttle_pkg;

    localparam int LOG_W  = 5;
    localparam int CNT_W  = 32;
    localparam int MISS_W = 16;

    function automatic logic [CNT_W-1:0] slot_max(input logic [LOG_W-1:0] log_thr);
        return CNT_W'(1) << log_thr;
    endfunction

endpackage

// File: rtl/axis_throttle_slot.sv
// Per-channel slot timer: grants one transmit slot every 2^log_throttle cycles.
// Pending updates on the cycle after a wrap; an accept consumes the slot, but a
// simultaneous wrap wins. Optional AXIS_THROTTLE_ARB_MISS_CNT_EN adds miss_count.
module axis_throttle_slot
    import axis_throttle_pkg::*;
(
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             enable,
    input  logic [LOG_W-1:0] log_throttle,
    input  logic             accept,
    output logic             pending
`ifdef AXIS_THROTTLE_ARB_MISS_CNT_EN
    ,
    output logic [MISS_W-1:0] miss_count
`endif
);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] slot_last;
    logic             wrap;

    // ">=" rather than "==" so a lowered exponent resynchronises on the next cycle.
    assign slot_last = slot_max(log_throttle) - CNT_W'(1);
    assign wrap      = count >= slot_last;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            count   <= '0;
            pending <= 1'b0;
        end else if (!enable) begin
            count   <= '0;
            pending <= 1'b0;
        end else begin
            count <= wrap ? '0 : count + CNT_W'(1);
            if (wrap)
                pending <= 1'b1;
            else if (accept)
                pending <= 1'b0;
        end
    end

`ifdef AXIS_THROTTLE_ARB_MISS_CNT_EN
    // A slot is lost only when a new one arrives on top of an unconsumed one.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            miss_count <= '0;
        else if (!enable)
            miss_count <= '0;
        else if (wrap && pending && !accept && (miss_count != {MISS_W{1'b1}}))
            miss_count <= miss_count + MISS_W'(1);
    end
`endif

endmodule

// File: rtl/axis_throttle_arbiter.sv
// Rate-limited round-robin mux of NUM_CH AXI-Stream slaves onto one master, tuser = channel.
// Latency: 1 cycle from slave accept to registered master beat; back-to-back capable.
// Backpressure: a stalled master holds its beat and gates every slave tready. Option: AXIS_THROTTLE_ARB_MISS_CNT_EN.
module axis_throttle_arbiter
    import axis_throttle_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int NUM_CH           = 4,
    parameter int CH_W             = 2
) (
    input  logic                               aclk,
    input  logic                               aresetn,
    input  logic                               enable,
    input  logic [LOG_W*NUM_CH-1:0]            log_throttle,
    input  logic [NUM_CH-1:0]                  S_AXIS_tvalid,
    output logic [NUM_CH-1:0]                  S_AXIS_tready,
    input  logic [AXIS_TDATA_WIDTH*NUM_CH-1:0] S_AXIS_tdata,
    output logic                               M_AXIS_tvalid,
    input  logic                               M_AXIS_tready,
    output logic [AXIS_TDATA_WIDTH-1:0]        M_AXIS_tdata,
    output logic [CH_W-1:0]                    M_AXIS_tuser
`ifdef AXIS_THROTTLE_ARB_MISS_CNT_EN
    ,
    output logic [NUM_CH*MISS_W-1:0]           miss_count
`endif
);

    logic [NUM_CH-1:0]           pending;
    logic [NUM_CH-1:0]           elig;
    logic [NUM_CH-1:0]           accept;
    logic [CH_W-1:0]             rr_ptr;
    logic [CH_W-1:0]             gnt;
    logic [CH_W-1:0]             cand;
    logic                        gnt_vld;
    logic                        load_ok;
    logic [AXIS_TDATA_WIDTH-1:0] sel_dat;
    int                          sum;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_slot
        axis_throttle_slot u_slot (
            .aclk         (aclk),
            .aresetn      (aresetn),
            .enable       (enable),
            .log_throttle (log_throttle[LOG_W*ch +: LOG_W]),
            .accept       (accept[ch]),
            .pending      (pending[ch])
`ifdef AXIS_THROTTLE_ARB_MISS_CNT_EN
            ,
            .miss_count   (miss_count[MISS_W*ch +: MISS_W])
`endif
        );
    end

    assign elig    = pending & S_AXIS_tvalid;
    assign load_ok = ~M_AXIS_tvalid | M_AXIS_tready;

    // Search starts just past the last winner, so the previous grant has lowest priority.
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        sum     = 0;
        cand    = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            sum  = (int'(rr_ptr) + i) % NUM_CH;
            cand = sum[CH_W-1:0];
            if (!gnt_vld && elig[cand]) begin
                gnt_vld = 1'b1;
                gnt     = cand;
            end
        end
    end

    always_comb begin
        accept  = '0;
        sel_dat = '0;
        if (gnt_vld && load_ok)
            accept[gnt] = 1'b1;
        for (int c = 0; c < NUM_CH; c++)
            if (gnt == CH_W'(c))
                sel_dat = S_AXIS_tdata[AXIS_TDATA_WIDTH*c +: AXIS_TDATA_WIDTH];
    end

    // Elig already includes tvalid, so tready doubles as the accept strobe.
    assign S_AXIS_tready = accept;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            M_AXIS_tvalid <= 1'b0;
            M_AXIS_tdata  <= '0;
            M_AXIS_tuser  <= '0;
            rr_ptr        <= CH_W'(NUM_CH - 1);
        end else if (gnt_vld && load_ok) begin
            M_AXIS_tvalid <= 1'b1;
            M_AXIS_tdata  <= sel_dat;
            M_AXIS_tuser  <= gnt;
            rr_ptr        <= gnt;
        end else if (M_AXIS_tready) begin
            M_AXIS_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_throttle_arbiter.sv
// Directed bench for axis_throttle_arbiter: expected beats queued as stimulus is set up,
// popped and compared as the master port hands them off.
module tb_axis_throttle_arbiter;

    localparam int W  = 32;
    localparam int NC = 4;

    typedef struct packed {
        logic [1:0]   usr;
        logic [W-1:0] dat;
    } exp_t;

    logic            aclk;
    logic            aresetn;
    logic            enable;
    logic [5*NC-1:0] log_throttle;
    logic [NC-1:0]   S_AXIS_tvalid;
    logic [NC-1:0]   S_AXIS_tready;
    logic [W*NC-1:0] S_AXIS_tdata;
    logic            M_AXIS_tvalid;
    logic            M_AXIS_tready;
    logic [W-1:0]    M_AXIS_tdata;
    logic [1:0]      M_AXIS_tuser;

    logic [23:0]     tag;
    exp_t            sb[$];
    int              beat_cyc[$];
    int              ch_beats[NC];
    int              cyc;
    int              n_cmp;
    int              n_err;
    int              c0;
    logic            stall_prev;
    logic [W-1:0]    stall_dat;
    logic [1:0]      stall_usr;

    axis_throttle_arbiter #(
        .AXIS_TDATA_WIDTH (W),
        .NUM_CH           (NC),
        .CH_W             (2)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .enable        (enable),
        .log_throttle  (log_throttle),
        .S_AXIS_tvalid (S_AXIS_tvalid),
        .S_AXIS_tready (S_AXIS_tready),
        .S_AXIS_tdata  (S_AXIS_tdata),
        .M_AXIS_tvalid (M_AXIS_tvalid),
        .M_AXIS_tready (M_AXIS_tready),
        .M_AXIS_tdata  (M_AXIS_tdata),
        .M_AXIS_tuser  (M_AXIS_tuser)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    // Each source presents a fixed word: channel marker plus a per-phase tag.
    always_comb begin
        S_AXIS_tdata = '0;
        for (int c = 0; c < NC; c++)
            S_AXIS_tdata[W*c +: W] = {8'(8'hA0 + c), tag};
    end

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic push(input int c);
        exp_t e;
        e.usr = 2'(c);
        e.dat = {8'(8'hA0 + c), tag};
        sb.push_back(e);
    endtask

    task automatic set_log(input logic [4:0] l0, input logic [4:0] l1,
                           input logic [4:0] l2, input logic [4:0] l3);
        log_throttle = {l3, l2, l1, l0};
    endtask

    task automatic idle();
        enable        = 1'b0;
        S_AXIS_tvalid = '0;
        M_AXIS_tready = 1'b1;
        step(4);
    endtask

    task automatic phase_start();
        beat_cyc.delete();
        for (int c = 0; c < NC; c++) ch_beats[c] = 0;
    endtask

    function automatic int beat_at(input int i);
        return (beat_cyc.size() > i) ? beat_cyc[i] : -1;
    endfunction

    // Output monitor: protocol invariants, stall stability and scoreboard pop.
    always @(negedge aclk) begin
        exp_t e;
        if (aresetn) begin
            chk("rdy_subset_onehot",
                64'(((S_AXIS_tready & ~S_AXIS_tvalid) == '0) && $onehot0(S_AXIS_tready)), 64'd1);
            if (stall_prev) begin
                chk("stall_vld", 64'(M_AXIS_tvalid), 64'd1);
                chk("stall_dat", 64'(M_AXIS_tdata), 64'(stall_dat));
                chk("stall_usr", 64'(M_AXIS_tuser), 64'(stall_usr));
            end
            if (M_AXIS_tvalid && M_AXIS_tready) begin
                beat_cyc.push_back(cyc);
                if (M_AXIS_tuser !== 2'bxx) ch_beats[M_AXIS_tuser]++;
                if (sb.size() == 0) begin
                    chk("sb_unexpected_beat", 64'(M_AXIS_tuser), 64'hFFFF);
                end else begin
                    e = sb.pop_front();
                    chk("beat_tuser", 64'(M_AXIS_tuser), 64'(e.usr));
                    chk("beat_tdata", 64'(M_AXIS_tdata), 64'(e.dat));
                end
            end
            stall_prev = M_AXIS_tvalid && !M_AXIS_tready;
            stall_dat  = M_AXIS_tdata;
            stall_usr  = M_AXIS_tuser;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        stall_prev    = 1'b0;
        stall_dat     = '0;
        stall_usr     = '0;
        aresetn       = 1'b0;
        enable        = 1'b0;
        log_throttle  = '0;
        S_AXIS_tvalid = '0;
        M_AXIS_tready = 1'b0;
        tag           = 24'h000000;
        phase_start();

        // Reset values
        step(3);
        chk("rst_m_tvalid", 64'(M_AXIS_tvalid), 64'd0);
        chk("rst_m_tdata", 64'(M_AXIS_tdata), 64'd0);
        chk("rst_m_tuser", 64'(M_AXIS_tuser), 64'd0);
        chk("rst_s_tready", 64'(S_AXIS_tready), 64'd0);
        aresetn = 1'b1;
        idle();

        // All channels at full rate, then a 5-cycle stall: 0,1,2,3,... without loss or bubble
        phase_start();
        set_log(0, 0, 0, 0);
        tag = 24'h000111;
        for (int i = 0; i < 15; i++) push(i % 4);
        S_AXIS_tvalid = 4'b1111;
        c0 = cyc;
        enable = 1'b1;
        step(8);
        M_AXIS_tready = 1'b0;
        step(5);
        M_AXIS_tready = 1'b1;
        step(8);
        enable = 1'b0;
        S_AXIS_tvalid = '0;
        step(3);
        chk("full_beats", 64'(beat_cyc.size()), 64'd15);
        chk("full_first_lat", 64'(beat_at(0) - c0), 64'd2);
        for (int i = 0; i < 5; i++)
            chk("full_no_bubble", 64'(beat_at(i + 1) - beat_at(i)), 64'd1);
        chk("full_after_stall", 64'(beat_at(6) - c0), 64'd13);
        chk("full_sb_left", 64'(sb.size()), 64'd0);
        idle();

        // Single channel, log=3: one beat every 8 cycles
        phase_start();
        set_log(3, 0, 0, 0);
        tag = 24'h000222;
        for (int i = 0; i < 4; i++) push(0);
        S_AXIS_tvalid = 4'b0001;
        c0 = cyc;
        enable = 1'b1;
        step(40);
        enable = 1'b0;
        S_AXIS_tvalid = '0;
        step(3);
        chk("single_beats", 64'(beat_cyc.size()), 64'd4);
        chk("single_first_lat", 64'(beat_at(0) - c0), 64'd9);
        for (int i = 0; i < 3; i++)
            chk("single_gap", 64'(beat_at(i + 1) - beat_at(i)), 64'd8);
        chk("single_sb_left", 64'(sb.size()), 64'd0);
        idle();

        // ch1 log=2 vs ch2 log=4: 4:1 ratio; on ties ch2 wins because ch1 was granted last
        phase_start();
        set_log(0, 2, 4, 0);
        tag = 24'h000333;
        push(1); push(1); push(1);
        for (int k = 0; k < 4; k++) begin
            push(2);
            for (int j = 0; j < ((k < 3) ? 4 : 1); j++) push(1);
        end
        S_AXIS_tvalid = 4'b0110;
        c0 = cyc;
        enable = 1'b1;
        step(66);
        enable = 1'b0;
        S_AXIS_tvalid = '0;
        step(3);
        chk("ratio_ch1", 64'(ch_beats[1]), 64'd16);
        chk("ratio_ch2", 64'(ch_beats[2]), 64'd4);
        chk("ratio_first_tie", 64'(beat_at(3) - c0), 64'd17);
        chk("ratio_sb_left", 64'(sb.size()), 64'd0);
        idle();

        // ch0 log=2 idle for 12 cycles: merged slots give exactly one immediate beat
        phase_start();
        set_log(2, 0, 0, 0);
        tag = 24'h000444;
        push(0);
        c0 = cyc;
        enable = 1'b1;
        step(12);
        S_AXIS_tvalid = 4'b0001;
        #1;
        chk("merge_rdy", 64'(S_AXIS_tready), 64'h1);
        step(4);
        S_AXIS_tvalid = '0;
        enable = 1'b0;
        step(3);
        chk("merge_beats", 64'(beat_cyc.size()), 64'd1);
        chk("merge_lat", 64'(beat_at(0) - c0), 64'd13);
        chk("merge_sb_left", 64'(sb.size()), 64'd0);
        idle();

        // enable dropped with a beat stalled: it drains, no new grants until re-enable
        phase_start();
        set_log(0, 0, 0, 1);
        tag = 24'h000555;
        push(3); push(3);
        S_AXIS_tvalid = 4'b1000;
        M_AXIS_tready = 1'b0;
        c0 = cyc;
        enable = 1'b1;
        step(5);
        enable = 1'b0;
        step(2);
        chk("dis_hold_vld", 64'(M_AXIS_tvalid), 64'd1);
        chk("dis_rdy", 64'(S_AXIS_tready), 64'h0);
        M_AXIS_tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("dis_no_rdy", 64'(S_AXIS_tready), 64'h0);
        end
        chk("dis_drained", 64'(beat_cyc.size()), 64'd1);
        chk("dis_drain_cyc", 64'(beat_at(0) - c0), 64'd7);
        c0 = cyc;
        enable = 1'b1;
        step(1);
        chk("reen_early", 64'(S_AXIS_tready), 64'h0);
        step(1);
        chk("reen_slot", 64'(S_AXIS_tready), 64'h8);
        step(1);
        S_AXIS_tvalid = '0;
        enable = 1'b0;
        step(3);
        chk("reen_beats", 64'(beat_cyc.size()), 64'd2);
        chk("reen_lat", 64'(beat_at(1) - c0), 64'd3);
        chk("reen_sb_left", 64'(sb.size()), 64'd0);
        idle();

        // Asynchronous reset mid-stream: beat discarded, first grant afterwards is ch0
        phase_start();
        set_log(0, 0, 0, 0);
        tag = 24'h000666;
        push(0); push(1); push(2); push(3);
        S_AXIS_tvalid = 4'b1111;
        enable = 1'b1;
        step(6);
        #1;
        aresetn = 1'b0;
        #1;
        chk("arst_m_tvalid", 64'(M_AXIS_tvalid), 64'd0);
        chk("arst_s_tready", 64'(S_AXIS_tready), 64'h0);
        chk("arst_m_tdata", 64'(M_AXIS_tdata), 64'd0);
        chk("arst_m_tuser", 64'(M_AXIS_tuser), 64'd0);
        chk("arst_beats", 64'(beat_cyc.size()), 64'd4);
        chk("arst_sb_left", 64'(sb.size()), 64'd0);
        step(2);
        phase_start();
        tag = 24'h000777;
        push(0); push(1);
        c0 = cyc;
        aresetn = 1'b1;
        step(3);
        S_AXIS_tvalid = '0;
        enable = 1'b0;
        step(3);
        chk("post_rst_beats", 64'(beat_cyc.size()), 64'd2);
        chk("post_rst_lat", 64'(beat_at(0) - c0), 64'd2);
        chk("post_rst_sb_left", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
